hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard controller for the 5-stage MIPS core: drives the stall/flush controls consumed by the PC register, the F/D register and the D/E register. Decides each cycle whether the instruction in D may advance, using Tuse/Tnew comparison against the instructions in E and M. Tracks the multi-cycle multiply/divide unit's busy window with an internal down-counter. Keeps a free-running stall-cycle counter for performance checks.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles loaded for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles loaded for div/divu (1..15)

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- D_rs_addr  in  5  rs field of instr in D
- D_rt_addr  in  5  rt field of instr in D
- D_tuse_rs  in  2  cycles until D instr needs rs (0,1,2; 3 = not used)
- D_tuse_rt  in  2  same for rt
- D_is_md  in  1  D instr touches HI/LO or MDU (mult*, div*, mfhi, mflo, mthi, mtlo)
- E_A3  in  5  destination reg of instr in E (0 = none)
- E_tnew  in  2  cycles until E instr's result is forwardable
- M_A3  in  5  destination reg of instr in M
- M_tnew  in  2  same for M
- E_md_start  in  1  instr in E is mult/multu/div/divu this cycle
- E_md_is_div  in  1  qualifies E_md_start: 1 = div/divu
- pc_we  out  1  PC write enable
- fd_we  out  1  F/D register write enable
- de_we  out  1  D/E register write enable
- de_flush  out  1  D/E register loads a nop (bubble)
- md_busy  out  1  MDU busy this cycle
- stall_cnt  out  32  number of stall cycles since reset

## Operation
- Register hazard, per source s in {rs, rt}, per stage X in {E, M}: hit = (D_s_addr != 0) && (D_s_addr == X_A3) && (D_tuse_s < X_tnew). tuse = 3 never hits.
- md_count (4-bit, internal): on E_md_start with md_count == 0, load DIV_CYCLES if E_md_is_div else MULT_CYCLES; otherwise if md_count != 0, decrement by 1. E_md_start while md_count != 0 is ignored (count keeps decrementing).
- md_busy = E_md_start || (md_count != 0), combinational.
- stall = any register hit || (D_is_md && md_busy).
- stall = 1: pc_we = 0, fd_we = 0, de_flush = 1, de_we = 1. stall = 0: pc_we = fd_we = de_we = 1, de_flush = 0.
- stall_cnt increments by 1 on every posedge where stall = 1 and reset = 0; wraps 0xFFFF_FFFF -> 0.
- Reset: md_count = 0, stall_cnt = 0. While reset is high, outputs forced to pc_we = fd_we = de_we = 1, de_flush = 0, md_busy = 0, regardless of inputs.

## Timing
- All enables/flush are combinational from current inputs and md_count; zero-cycle latency, sampled by downstream registers at the same posedge.
- Mult started in cycle T (E_md_start = 1): md_busy high in T and T+1..T+MULT_CYCLES (6 cycles default); low from T+6. Div: high T..T+10.
- A D_is_md instr held in D during the busy window advances in the first cycle md_busy = 0.
- Register stall lasts until E/M Tnew decrements enough (inputs change as bubbles advance); block holds no register-hazard state.
- Simultaneous register hit and MDU stall: single stall, stall_cnt +1 only.
- Reset asserted mid-busy: md_count = 0 next cycle, md_busy = 0 from the first cycle after reset deasserts (unless E_md_start).
- E_A3 == 0 with matching addr 0: never stalls.

## Test plan
- lw $1 in E (E_A3=1, E_tnew=2), D add reads $1 (tuse_rs=1) -> pc_we=fd_we=0, de_flush=1; stall_cnt 0 -> 1 after edge.
- Same but E_A3=0, D_rs_addr=0 -> no stall, pc_we=1, de_flush=0, stall_cnt unchanged.
- M_A3=5, M_tnew=1, D beq rt=5 tuse_rt=0 -> stall; change M_tnew=0 -> stall released same cycle.
- E_md_start=1, E_md_is_div=0 at T, D mflo from T+1 -> md_busy high T..T+5, de_flush high T+1..T+5, released T+6; stall_cnt = 5.
- div at T, reset pulsed at T+3 -> md_count 0, md_busy 0, stall_cnt 0 at T+4; outputs forced non-stall during reset.
- Preload 0xFFFF_FFFF via 2^32 stall cycles (or force), one more stall -> stall_cnt = 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Pipeline interlock for the 5-stage MIPS core. Each cycle it decides whether
// the instruction in D may advance. It compares the Tuse of D's sources with
// the Tnew of the producers in E and M. It also stalls HI/LO/MDU instructions
// while the multiply/divide unit is busy, and counts stall cycles.
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,   // busy cycles after mult/multu (1..15)
  parameter int unsigned DIV_CYCLES  = 10   // busy cycles after div/divu   (1..15)
) (
  input  logic        clk,
  input  logic        reset,        // synchronous, active-high

  // Instruction in D
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_tuse_rs,    // 3 = source not read
  input  logic [1:0]  D_tuse_rt,
  input  logic        D_is_md,

  // Producers in E and M
  input  logic [4:0]  E_A3,         // 0 = no destination
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  M_tnew,

  // Multiply/divide launch from E
  input  logic        E_md_start,
  input  logic        E_md_is_div,

  // Pipeline register controls
  output logic        pc_we,
  output logic        fd_we,
  output logic        de_we,
  output logic        de_flush,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  // Remaining MDU busy cycles after the launch cycle; 0 = idle.
  logic [3:0]  md_count_q, md_count_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic        rs_hit_e, rs_hit_m, rt_hit_e, rt_hit_m;
  logic        reg_hit;
  logic        md_active;
  logic        md_busy_raw;
  logic        stall;

  // A source hits a producer when the register is real, matches the
  // destination, and is needed before the producer can forward it. Tuse 3
  // can never be below a 2-bit Tnew, so unused sources drop out for free.
  always_comb begin
    rs_hit_e = (D_rs_addr != 5'd0) && (D_rs_addr == E_A3) && (D_tuse_rs < E_tnew);
    rs_hit_m = (D_rs_addr != 5'd0) && (D_rs_addr == M_A3) && (D_tuse_rs < M_tnew);
    rt_hit_e = (D_rt_addr != 5'd0) && (D_rt_addr == E_A3) && (D_tuse_rt < E_tnew);
    rt_hit_m = (D_rt_addr != 5'd0) && (D_rt_addr == M_A3) && (D_tuse_rt < M_tnew);
    reg_hit  = rs_hit_e | rs_hit_m | rt_hit_e | rt_hit_m;
  end

  // MDU busy covers the launch cycle itself plus the counted-down window.
  // A single stall is raised even when a register hit coincides with a busy
  // MDU, so the counter only advances once per cycle.
  always_comb begin
    md_active   = (md_count_q != 4'd0);
    md_busy_raw = E_md_start | md_active;
    stall       = reg_hit | (D_is_md & md_busy_raw);
  end

  // Next MDU count: a launch loads only when idle. A launch while the unit
  // is busy is ignored and the count keeps running down.
  always_comb begin
    // NOTE: assign a default first so every path writes the signal; otherwise always_comb infers a latch.
    md_count_d = md_count_q;
    if (E_md_start && !md_active) begin
      md_count_d = E_md_is_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_active) begin
      md_count_d = md_count_q - 4'd1;
    end
  end

  // Stall-cycle counter, free-running and wrapping at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (reset) begin
      md_count_q  <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      md_count_q  <= md_count_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Drive the pipeline controls. While reset is high, the pipeline is held in
  // a plain advance state whatever the inputs are.
  always_comb begin
    pc_we    = 1'b1;
    fd_we    = 1'b1;
    de_we    = 1'b1;
    de_flush = 1'b0;
    md_busy  = 1'b0;
    if (!reset) begin
      md_busy = md_busy_raw;
      if (stall) begin
        pc_we    = 1'b0;
        fd_we    = 1'b0;
        de_flush = 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl. The driver applies one stimulus
// vector per cycle and pushes the expected response. The expected response
// comes from a cycle-indexed model: the MDU is tracked as a "busy until cycle
// N" window. A monitor on the falling edge pops each expectation and
// compares it with the DUT outputs.
module tb_hazard_stall_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct {
    logic       reset;
    logic [4:0] d_rs, d_rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic       is_md;
    logic [4:0] e_a3;
    logic [1:0] e_tnew;
    logic [4:0] m_a3;
    logic [1:0] m_tnew;
    logic       md_start, md_div;
  } stim_t;

  typedef struct {
    logic        pc_we, fd_we, de_we, de_flush, md_busy;
    logic [31:0] stall_cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  D_rs_addr = '0, D_rt_addr = '0, E_A3 = '0, M_A3 = '0;
  logic [1:0]  D_tuse_rs = 2'd3, D_tuse_rt = 2'd3, E_tnew = '0, M_tnew = '0;
  logic        D_is_md = 1'b0, E_md_start = 1'b0, E_md_is_div = 1'b0;
  logic        pc_we, fd_we, de_we, de_flush, md_busy;
  logic [31:0] stall_cnt;

  hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_is_md(D_is_md),
    .E_A3(E_A3), .E_tnew(E_tnew), .M_A3(M_A3), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
    .pc_we(pc_we), .fd_we(fd_we), .de_we(de_we), .de_flush(de_flush),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   drive_done = 1'b0;

  // Reference model state
  int          cyc = 0;
  int          busy_until = -1;   // MDU counts as busy in cycles cyc <= busy_until
  logic [31:0] model_cnt = '0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  function automatic bit src_hit(input logic [4:0] addr, input logic [1:0] tuse,
                                 input logic [4:0] a3, input logic [1:0] tnew);
    return (addr != 0) && (addr == a3) && (int'(tuse) < int'(tnew));
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{reset: 1'b0, d_rs: 5'd0, d_rt: 5'd0, tuse_rs: 2'd3, tuse_rt: 2'd3,
          is_md: 1'b0, e_a3: 5'd0, e_tnew: 2'd0, m_a3: 5'd0, m_tnew: 2'd0,
          md_start: 1'b0, md_div: 1'b0};
    return s;
  endfunction

  // Drive inputs, derive the expectation for this cycle, advance the model.
  task automatic apply(input stim_t s);
    exp_t e;
    bit   busy_prev, busy, stall;
    reset       = s.reset;
    D_rs_addr   = s.d_rs;    D_rt_addr = s.d_rt;
    D_tuse_rs   = s.tuse_rs; D_tuse_rt = s.tuse_rt;
    D_is_md     = s.is_md;
    E_A3        = s.e_a3;    E_tnew    = s.e_tnew;
    M_A3        = s.m_a3;    M_tnew    = s.m_tnew;
    E_md_start  = s.md_start;
    E_md_is_div = s.md_div;

    busy_prev = (cyc <= busy_until);
    busy      = s.md_start || busy_prev;
    stall     = src_hit(s.d_rs, s.tuse_rs, s.e_a3, s.e_tnew) ||
                src_hit(s.d_rs, s.tuse_rs, s.m_a3, s.m_tnew) ||
                src_hit(s.d_rt, s.tuse_rt, s.e_a3, s.e_tnew) ||
                src_hit(s.d_rt, s.tuse_rt, s.m_a3, s.m_tnew) ||
                (s.is_md && busy);
    e.stall_cnt = model_cnt;
    if (s.reset) begin
      e.pc_we = 1; e.fd_we = 1; e.de_we = 1; e.de_flush = 0; e.md_busy = 0;
      model_cnt  = '0;
      busy_until = -1;
    end else begin
      e.pc_we = !stall; e.fd_we = !stall; e.de_we = 1'b1;
      e.de_flush = stall; e.md_busy = busy;
      if (stall) model_cnt = model_cnt + 32'd1;
      if (s.md_start && !busy_prev) busy_until = cyc + (s.md_div ? DIV_N : MULT_N);
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    apply(s);
  endtask

  // Monitor: compare every presented output against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pc_we",     32'(pc_we),    32'(e.pc_we));
        check("fd_we",     32'(fd_we),    32'(e.fd_we));
        check("de_we",     32'(de_we),    32'(e.de_we));
        check("de_flush",  32'(de_flush), 32'(e.de_flush));
        check("md_busy",   32'(md_busy),  32'(e.md_busy));
        check("stall_cnt", stall_cnt,     e.stall_cnt);
      end
    end
  end

  // Driver
  initial begin
    stim_t s;
    repeat (2) @(posedge clk);

    // lw $1 in E, add reads $1 in D: stall
    s = idle(); s.e_a3 = 5'd1; s.e_tnew = 2'd2; s.d_rs = 5'd1; s.tuse_rs = 2'd1;
    step(s);
    // Same with register 0 on both sides: never stalls
    s.e_a3 = 5'd0; s.d_rs = 5'd0;
    step(s);
    // beq rt=5 vs M producer with tnew 1, then tnew 0 releases
    s = idle(); s.m_a3 = 5'd5; s.m_tnew = 2'd1; s.d_rt = 5'd5; s.tuse_rt = 2'd0;
    step(s);
    s.m_tnew = 2'd0;
    step(s);
    // tuse 3 never stalls even against a far producer
    s = idle(); s.e_a3 = 5'd7; s.e_tnew = 2'd3; s.d_rs = 5'd7; s.tuse_rs = 2'd3;
    step(s);

    // mult at T, mflo held in D from T+1 until released
    s = idle(); s.md_start = 1'b1; s.md_div = 1'b0;
    step(s);
    s = idle(); s.is_md = 1'b1;
    repeat (MULT_N + 2) step(s);

    // Register hit and MDU stall together count once
    s = idle(); s.md_start = 1'b1; s.is_md = 1'b1;
    s.e_a3 = 5'd3; s.e_tnew = 2'd1; s.d_rs = 5'd3; s.tuse_rs = 2'd0;
    step(s);
    s = idle(); s.is_md = 1'b1;
    repeat (MULT_N) step(s);

    // div at T, reset pulsed at T+3 with busy-looking inputs
    s = idle(); s.md_start = 1'b1; s.md_div = 1'b1;
    step(s);
    s = idle(); s.is_md = 1'b1;
    step(s); step(s);
    s.reset = 1'b1; s.md_start = 1'b1; s.e_a3 = 5'd2; s.e_tnew = 2'd2; s.d_rs = 5'd2; s.tuse_rs = 2'd0;
    step(s);
    s = idle(); s.is_md = 1'b1;
    step(s); step(s);

    // Wrap: preload the counter to all ones, then one stall cycle
    s = idle(); s.e_a3 = 5'd9; s.e_tnew = 2'd2; s.d_rt = 5'd9; s.tuse_rt = 2'd0;
    @(posedge clk);
    #1;
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    model_cnt = 32'hFFFF_FFFF;
    apply(s);
    @(negedge clk);
    #1;
    release dut.stall_cnt_q;
    step(idle());
    step(idle());

    // Randomised traffic with small register numbers to provoke matches
    for (int i = 0; i < 400; i++) begin
      s.reset    = ($urandom_range(0, 49) == 0);
      s.d_rs     = 5'($urandom_range(0, 3));
      s.d_rt     = 5'($urandom_range(0, 3));
      s.tuse_rs  = 2'($urandom_range(0, 3));
      s.tuse_rt  = 2'($urandom_range(0, 3));
      s.is_md    = ($urandom_range(0, 2) == 0);
      s.e_a3     = 5'($urandom_range(0, 3));
      s.e_tnew   = 2'($urandom_range(0, 3));
      s.m_a3     = 5'($urandom_range(0, 3));
      s.m_tnew   = 2'($urandom_range(0, 3));
      s.md_start = ($urandom_range(0, 7) == 0);
      s.md_div   = 1'($urandom_range(0, 1));
      step(s);
    end
    drive_done = 1'b1;
  end

  // Completion: wait for the driver, drain the scoreboard within a bound.
  initial begin
    int guard;
    guard = 0;
    while (!drive_done && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    if (!drive_done) begin
      n_checks++;
      n_errors++;
      $display("FAIL driver_timeout: driver did not finish, expected done within 5000 cycles");
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
